nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_pkg.sv | 17 +
 rtl/rca_4bit.sv | 21 ++
 rtl/nibble_serial_adder.sv | 122 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIB_W = 4;

    // Index register width for a given nibble count; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/rca_4bit.sv
// Existing 4-bit ripple-carry adder used as the shared nibble datapath.
module rca_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/sub that steps operand nibbles through one rca_4bit,
// carrying between nibbles in a register; result published only when complete.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_t             state;
    state_t             state_next;
    logic               busy_d;
    logic               done_d;

    logic [WIDTH-1:0]   a_lat;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   acc;
    logic               c_reg;
    logic [IDX_W-1:0]   idx;

    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic [NIB_W-1:0]   nib_sum;
    logic               nib_cout;
    logic [WIDTH-1:0]   result;
    logic               last;

    // Current nibble selected by shifting the latched operands down by 4*idx.
    assign nib_a  = NIB_W'(a_lat >> {idx, 2'b00});
    assign nib_b  = NIB_W'(b_eff >> {idx, 2'b00});
    assign result = acc | (WIDTH'(nib_sum) << {idx, 2'b00});
    assign last   = (idx == IDX_LAST);

    rca_4bit u_rca (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (c_reg),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state, then registered.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_next == RUN)  busy_d = 1'b1;
        if (state_next == DONE) done_d = 1'b1;
    end

    // Operand capture, nibble accumulation and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            a_lat    <= '0;
            b_eff    <= '0;
            acc      <= '0;
            c_reg    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (state == IDLE && start) begin
                a_lat <= a;
                b_eff <= sub ? ~b : b;
                c_reg <= sub | cin;
                acc   <= '0;
                idx   <= '0;
            end else if (state == RUN) begin
                acc   <= result;
                c_reg <= nib_cout;
                idx   <= last ? '0 : idx + IDX_W'(1);
                if (last) begin
                    sum      <= result;
                    cout     <= nib_cout;
                    overflow <= (a_lat[WIDTH-1] == b_eff[WIDTH-1]) &&
                                (result[WIDTH-1] != a_lat[WIDTH-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start, sub, cin;
    logic [15:0] a, b;
    logic        busy, done, cout, overflow;
    logic [15:0] sum;

    logic        start4, sub4, cin4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, cout4, overflow4;
    logic [3:0]  sum4;

    int checks;
    int failures;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one 16-bit op, scramble inputs afterwards, and report the cycle
    // (counted from the start edge) where done rose plus per-cycle busy samples.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         input logic cv, output int cyc, output logic [15:0] bh);
        @(negedge clk);
        a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
        cyc = -1;
        bh  = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                a = 16'($urandom);
                b = 16'($urandom);
                sub = ~sv;
                cin = ~cv;
            end
            bh = bh | (16'(busy) << c);
            if (done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, overflow} !== 19'd0) begin
            failures++;
            $display("FAIL reset16 got busy=%b done=%b sum=%h cout=%b ov=%b exp all zero",
                     busy, done, sum, cout, overflow);
        end
        checks++;
        if ({busy4, done4, sum4, cout4, overflow4} !== 7'd0) begin
            failures++;
            $display("FAIL reset4 got busy=%b done=%b sum=%h cout=%b ov=%b exp all zero",
                     busy4, done4, sum4, cout4, overflow4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_carry();
        int cyc;
        logic [15:0] bh;
        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, cyc, bh);
        checks++;
        if (cyc != 5) begin
            failures++;
            $display("FAIL add_latency got=%0d exp=5", cyc);
        end
        checks++;
        if (bh !== 16'h001E) begin
            failures++;
            $display("FAIL add_busy_cycles got=%h exp=001e", bh);
        end
        checks++;
        if ({sum, cout, overflow} !== {16'h2233, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add_result got sum=%h cout=%b ov=%b exp sum=2233 cout=0 ov=0",
                     sum, cout, overflow);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL add_done_pulse got done=%b busy=%b exp done=0 busy=0", done, busy);
        end
        do_op(16'h00FF, 16'h0000, 1'b0, 1'b1, cyc, bh);
        checks++;
        if ({sum, cout, overflow} !== {16'h0100, 1'b0, 1'b0} || cyc != 5) begin
            failures++;
            $display("FAIL add_cin got sum=%h cout=%b ov=%b cyc=%0d exp sum=0100 cout=0 ov=0 cyc=5",
                     sum, cout, overflow, cyc);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        logic [15:0] bh;
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, cyc, bh);
        checks++;
        if ({sum, cout, overflow} !== {16'h0000, 1'b1, 1'b0} || cyc != 5) begin
            failures++;
            $display("FAIL wrap_full got sum=%h cout=%b ov=%b cyc=%0d exp sum=0000 cout=1 ov=0 cyc=5",
                     sum, cout, overflow, cyc);
        end
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, cyc, bh);
        checks++;
        if ({sum, cout, overflow} !== {16'h8000, 1'b0, 1'b1} || cyc != 5) begin
            failures++;
            $display("FAIL wrap_ovf got sum=%h cout=%b ov=%b cyc=%0d exp sum=8000 cout=0 ov=1 cyc=5",
                     sum, cout, overflow, cyc);
        end
    endtask

    task automatic test_sub();
        int cyc;
        logic [15:0] bh;
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, cyc, bh);
        checks++;
        if ({sum, cout, overflow} !== {16'hFFFE, 1'b0, 1'b0} || cyc != 5) begin
            failures++;
            $display("FAIL sub_borrow got sum=%h cout=%b ov=%b cyc=%0d exp sum=fffe cout=0 ov=0 cyc=5",
                     sum, cout, overflow, cyc);
        end
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0, cyc, bh);
        checks++;
        if ({sum, cout, overflow} !== {16'h7FFF, 1'b1, 1'b1} || cyc != 5) begin
            failures++;
            $display("FAIL sub_ovf got sum=%h cout=%b ov=%b cyc=%0d exp sum=7fff cout=1 ov=1 cyc=5",
                     sum, cout, overflow, cyc);
        end
    endtask

    task automatic test_start_held();
        logic [5:0] dh;
        logic [11:6] dh2;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        dh = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            dh[c] = done;
            a = 16'($urandom);
            b = 16'($urandom);
        end
        checks++;
        if (dh[5:1] !== 5'b10000 || sum !== 16'h3333) begin
            failures++;
            $display("FAIL held_first got done_hist=%b sum=%h exp done_hist=10000 sum=3333",
                     dh[5:1], sum);
        end
        a = 16'h0AAA; b = 16'h0001;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL held_idle_gap got busy=%b done=%b exp busy=0 done=0", busy, done);
        end
        a = 16'h0100; b = 16'h0200;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL held_accept got busy=%b exp 1", busy);
        end
        start = 1'b0;
        dh2 = '0;
        for (int c = 8; c <= 11; c++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
            dh2[c] = done;
        end
        checks++;
        if (dh2[11:8] !== 4'b1000 || sum !== 16'h0300) begin
            failures++;
            $display("FAIL held_second got done_hist=%b sum=%h exp done_hist=1000 sum=0300",
                     dh2[11:8], sum);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen;
        logic [15:0] bh;
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout, overflow} !== 19'd0) begin
            failures++;
            $display("FAIL rst_mid got busy=%b done=%b sum=%h cout=%b ov=%b exp all zero",
                     busy, done, sum, cout, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_idle got active_cycles=%0d exp 0", seen);
        end
        do_op(16'h0101, 16'h0202, 1'b0, 1'b0, cyc, bh);
        checks++;
        if ({sum, cout, overflow} !== {16'h0303, 1'b0, 1'b0} || cyc != 5) begin
            failures++;
            $display("FAIL rst_recover got sum=%h cout=%b ov=%b cyc=%0d exp sum=0303 cout=0 ov=0 cyc=5",
                     sum, cout, overflow, cyc);
        end
    endtask

    task automatic test_width4();
        int cyc;
        logic [3:0] bh;
        @(negedge clk);
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; sub4 = 1'b0; start4 = 1'b1;
        cyc = -1;
        bh = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
            end
            bh = bh | (4'(busy4) << c);
            if (done4) begin
                cyc = c;
                break;
            end
        end
        checks++;
        if (cyc != 2 || bh !== 4'b0010) begin
            failures++;
            $display("FAIL w4_timing got cyc=%0d busy_hist=%b exp cyc=2 busy_hist=0010", cyc, bh);
        end
        checks++;
        if ({sum4, cout4, overflow4} !== {4'h2, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL w4_result got sum=%h cout=%b ov=%b exp sum=2 cout=1 ov=1",
                     sum4, cout4, overflow4);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add_carry();
        test_wrap();
        test_sub();
        test_start_held();
        test_reset_mid();
        test_width4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
